// File: rtl/dcache_mem_pkg.sv
// Shared definitions for the data-cache memory responder.
// Contents: size encodings, FSM state type and the alignment check.
package dcache_mem_pkg;

  // Access size encodings as presented on dcache_mem_size
  localparam logic [1:0] SIZE_B = 2'd0;
  localparam logic [1:0] SIZE_H = 2'd1;
  localparam logic [1:0] SIZE_W = 2'd2;

  // Responder transaction states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  // True when the access is not naturally aligned for its size.
  // The reserved size code always counts as misaligned.
  function automatic logic is_misaligned(input logic [1:0] size,
                                         input logic [1:0] addr_lo);
    logic bad;
    case (size)
      SIZE_B:  bad = 1'b0;
      SIZE_H:  bad = addr_lo[0];
      SIZE_W:  bad = (addr_lo != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/mem_bram_be.sv
// Single-port word array with per-byte write enables and a registered read.
// The read register only loads on a read strobe, so it holds the last
// read word across later writes.
module mem_bram_be #(
  parameter int depth_width = 10
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   re,
  input  logic [3:0]             we,
  input  logic [depth_width-1:0] addr,
  input  logic [31:0]            wdata,
  output logic [31:0]            rdata
);

  localparam int DEPTH = 1 << depth_width;

  logic [31:0] mem [0:DEPTH-1];

  // Byte-lane writes; lanes with a clear enable keep their old contents
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (we[i]) begin
        mem[addr][i*8 +: 8] <= wdata[i*8 +: 8];
      end
    end
  end

  // Registered read port, cleared by reset, loaded only on a read strobe
  always_ff @(posedge clk) begin
    if (!rstn) begin
      rdata <= 32'h0;
    end else if (re) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/dcache_mem_responder.sv
// Memory-side responder for the data cache request port.
// Accepts one request at a time in IDLE, waits a fixed latency, then pulses
// dataOK for one cycle. Writes and reads touch the array on the clock edge
// that enters RESP.
module dcache_mem_responder
  import dcache_mem_pkg::*;
#(
  parameter int depth_width = 10,
  parameter int latency     = 2    // legal range 1..15
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        dcache_mem_req,
  input  logic        dcache_mem_wr,
  input  logic [1:0]  dcache_mem_size,
  input  logic [3:0]  dcache_mem_wstrb,
  input  logic [31:0] addrout_dcache,
  input  logic [31:0] dout_dcache_mem,
  output logic [31:0] din_mem_dcache,
  output logic        mem_dcache_addrOK,
  output logic        mem_dcache_dataOK,
  output logic        mem_err
);

  localparam logic [3:0] LAT_M1 = 4'(latency - 1);

  state_t                 state_reg, state_next;
  logic [3:0]             cnt_reg, cnt_next;

  // Captured request fields
  logic [depth_width-1:0] idx_reg;
  logic                   wr_reg;
  logic [3:0]             wstrb_reg;
  logic [31:0]            wdata_reg;
  logic                   misal_reg;
  logic                   err_reg;

  logic                   handshake;
  logic                   req_misal;
  logic                   commit;
  logic                   use_live;
  logic                   acc_wr;
  logic                   acc_misal;
  logic [3:0]             acc_wstrb;
  logic [31:0]            acc_wdata;
  logic [depth_width-1:0] acc_idx;
  logic                   ram_re;
  logic [3:0]             ram_we;

  // Address bits above the array index alias and are intentionally dropped
  logic unused_addr_bits;
  assign unused_addr_bits = ^addrout_dcache[31:depth_width+2];

  assign handshake = (state_reg == IDLE) && dcache_mem_req;
  assign req_misal = is_misaligned(dcache_mem_size, addrout_dcache[1:0]);

  // Next-state and handshake outputs; counter loaded on acceptance
  always_comb begin
    state_next        = state_reg;
    cnt_next          = cnt_reg;
    mem_dcache_addrOK = 1'b0;
    mem_dcache_dataOK = 1'b0;
    case (state_reg)
      IDLE: begin
        mem_dcache_addrOK = dcache_mem_req;
        if (dcache_mem_req) begin
          if (latency == 1) begin
            state_next = RESP;
          end else begin
            state_next = WAIT;
            cnt_next   = LAT_M1;
          end
        end
      end
      WAIT: begin
        // Leaving with the count at one means the count reaches zero here
        if (cnt_reg == 4'd1) begin
          state_next = RESP;
          cnt_next   = 4'd0;
        end else begin
          cnt_next = cnt_reg - 4'd1;
        end
      end
      RESP: begin
        mem_dcache_dataOK = 1'b1;
        state_next        = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State and latency counter registers
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_reg <= IDLE;
      cnt_reg   <= 4'd0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  // Capture the request fields on the accepting edge
  always_ff @(posedge clk) begin
    if (!rstn) begin
      idx_reg   <= '0;
      wr_reg    <= 1'b0;
      wstrb_reg <= 4'h0;
      wdata_reg <= 32'h0;
      misal_reg <= 1'b0;
    end else if (handshake) begin
      idx_reg   <= addrout_dcache[depth_width+1:2];
      wr_reg    <= dcache_mem_wr;
      wstrb_reg <= dcache_mem_wstrb;
      wdata_reg <= dout_dcache_mem;
      misal_reg <= req_misal;
    end
  end

  // Sticky misalignment flag, set when a misaligned request is accepted
  always_ff @(posedge clk) begin
    if (!rstn) begin
      err_reg <= 1'b0;
    end else if (handshake && req_misal) begin
      err_reg <= 1'b1;
    end
  end

  assign mem_err = err_reg;

  // With a latency of one the array is accessed on the accepting edge
  // itself, before the capture registers load, so the live inputs are used.
  assign use_live  = (state_reg == IDLE);
  assign acc_wr    = use_live ? dcache_mem_wr    : wr_reg;
  assign acc_misal = use_live ? req_misal        : misal_reg;
  assign acc_wstrb = use_live ? dcache_mem_wstrb : wstrb_reg;
  assign acc_wdata = use_live ? dout_dcache_mem  : wdata_reg;
  assign acc_idx   = use_live ? addrout_dcache[depth_width+1:2] : idx_reg;

  // A reset edge never enters RESP, so it also cancels the pending access
  assign commit = (state_next == RESP) && rstn;
  assign ram_re = commit && !acc_wr;
  assign ram_we = (commit && acc_wr && !acc_misal) ? acc_wstrb : 4'h0;

  mem_bram_be #(
    .depth_width(depth_width)
  ) u_ram (
    .clk   (clk),
    .rstn  (rstn),
    .re    (ram_re),
    .we    (ram_we),
    .addr  (acc_idx),
    .wdata (acc_wdata),
    .rdata (din_mem_dcache)
  );

endmodule

// File: tb/tb_dcache_mem_responder.sv
// Scoreboard bench for dcache_mem_responder (latency 2).
// Drivers push the expected response cycle and read data; a negedge monitor
// pops and compares whenever dataOK is seen.
module tb_dcache_mem_responder;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        req = 1'b0;
  logic        wr = 1'b0;
  logic [1:0]  size = 2'd0;
  logic [3:0]  wstrb = 4'h0;
  logic [31:0] addr = 32'h0;
  logic [31:0] wdata = 32'h0;
  logic [31:0] din;
  logic        addr_ok;
  logic        data_ok;
  logic        err;

  int cyc = 0;
  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    int          cyc;
    logic [31:0] din;
    string       name;
  } exp_t;

  exp_t sb[$];

  dcache_mem_responder #(
    .depth_width (10),
    .latency     (2)
  ) dut (
    .clk               (clk),
    .rstn              (rstn),
    .dcache_mem_req    (req),
    .dcache_mem_wr     (wr),
    .dcache_mem_size   (size),
    .dcache_mem_wstrb  (wstrb),
    .addrout_dcache    (addr),
    .dout_dcache_mem   (wdata),
    .din_mem_dcache    (din),
    .mem_dcache_addrOK (addr_ok),
    .mem_dcache_dataOK (data_ok),
    .mem_err           (err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Monitor: every dataOK pulse must match the head of the scoreboard
  always @(negedge clk) begin : monitor
    exp_t e;
    if (data_ok === 1'b1) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_dataOK: got 1 expected 0 (cycle %0d)", cyc);
      end else begin
        e = sb.pop_front();
        check32({e.name, "_cycle"}, cyc, e.cyc);
        check32({e.name, "_din"}, din, e.din);
        check32({e.name, "_addrOK_in_resp"}, {31'b0, addr_ok}, 32'h0);
        $display("resp %s: cycle %0d din %h", e.name, cyc, din);
      end
    end
  end

  task automatic drain(input string name);
    int left;
    left = 0;
    for (int i = 0; i < 20; i++) begin
      if (sb.size() == 0) break;
      @(negedge clk);
    end
    left = sb.size();
    check32({name, "_drain"}, left, 0);
    sb.delete();
  endtask

  // One request: drive, wait for acceptance, record the expectation, drain
  task automatic issue(input string name, input logic w, input logic [1:0] sz,
                       input logic [3:0] strb, input logic [31:0] a,
                       input logic [31:0] d, input logic [31:0] exp_din);
    int hs;
    hs = -1;
    @(posedge clk);
    #1;
    req = 1'b1; wr = w; size = sz; wstrb = strb; addr = a; wdata = d;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (addr_ok === 1'b1) begin
        hs = cyc;
        break;
      end
    end
    if (hs < 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s_accept: got no addrOK expected addrOK within 20 cycles", name);
    end else begin
      sb.push_back('{hs + 2, exp_din, name});
      $display("req  %s: wr %0d addr %h data %h accepted cycle %0d", name, w, a, d, hs);
    end
    @(posedge clk);
    #1;
    req = 1'b0; wr = 1'b0; wstrb = 4'h0; wdata = 32'h0;
    drain(name);
  endtask

  initial begin : stim
    int hs[3];
    int n_hs;
    int quiet;

    // Known contents for the word at 0x20 used by the reset-abort case
    dut.u_ram.mem[8] = 32'h0;

    rstn = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check32("rst_addrOK", {31'b0, addr_ok}, 32'h0);
    check32("rst_dataOK", {31'b0, data_ok}, 32'h0);
    check32("rst_din", din, 32'h0);
    check32("rst_err", {31'b0, err}, 32'h0);
    @(posedge clk);
    #1;
    rstn = 1'b1;

    issue("wr_word",        1'b1, 2'd2, 4'hF, 32'h10,   32'hDEADBEEF, 32'h0);
    issue("rd_word",        1'b0, 2'd2, 4'h0, 32'h10,   32'h0,        32'hDEADBEEF);
    issue("wr_byte",        1'b1, 2'd0, 4'h4, 32'h12,   32'h00AA0000, 32'hDEADBEEF);
    issue("rd_merge",       1'b0, 2'd2, 4'h0, 32'h10,   32'h0,        32'hDEAABEEF);
    issue("wr_nostrb",      1'b1, 2'd2, 4'h0, 32'h10,   32'hFFFFFFFF, 32'hDEAABEEF);
    issue("rd_after_nostrb",1'b0, 2'd2, 4'h0, 32'h10,   32'h0,        32'hDEAABEEF);
    issue("rd_alias",       1'b0, 2'd2, 4'h0, 32'h1010, 32'h0,        32'hDEAABEEF);
    check32("err_aligned", {31'b0, err}, 32'h0);

    // Held request: three reads accepted every latency+1 cycles
    n_hs = 0;
    quiet = 0;
    @(posedge clk);
    #1;
    req = 1'b1; wr = 1'b0; size = 2'd2; wstrb = 4'h0; addr = 32'h10;
    for (int i = 0; i < 30; i++) begin
      if (n_hs == 3) break;
      @(negedge clk);
      if (addr_ok === 1'b1) begin
        hs[n_hs] = cyc;
        sb.push_back('{cyc + 2, 32'hDEAABEEF, "rd_held"});
        $display("req  rd_held: addr 00000010 accepted cycle %0d", cyc);
        n_hs++;
      end else begin
        quiet++;
      end
    end
    @(posedge clk);
    #1;
    req = 1'b0;
    check32("held_count", n_hs, 3);
    if (n_hs == 3) begin
      check32("held_gap1", hs[1] - hs[0], 3);
      check32("held_gap2", hs[2] - hs[1], 3);
    end
    check32("held_quiet_cycles", quiet, 4);
    drain("rd_held");

    // Misaligned word write: completes, suppressed, sets sticky error
    issue("wr_misal",       1'b1, 2'd2, 4'hF, 32'h11,   32'h12345678, 32'hDEAABEEF);
    check32("err_set", {31'b0, err}, 32'h1);
    issue("rd_after_misal", 1'b0, 2'd2, 4'h0, 32'h10,   32'h0,        32'hDEAABEEF);
    check32("err_sticky", {31'b0, err}, 32'h1);

    // Reset while a write is pending: no response, no commit
    @(posedge clk);
    #1;
    req = 1'b1; wr = 1'b1; size = 2'd2; wstrb = 4'hF; addr = 32'h20; wdata = 32'hCAFEF00D;
    @(negedge clk);
    check32("abort_accept", {31'b0, addr_ok}, 32'h1);
    $display("req  wr_abort: addr 00000020 data cafef00d accepted cycle %0d", cyc);
    @(posedge clk);
    #1;
    rstn = 1'b0; req = 1'b0; wr = 1'b0; wstrb = 4'h0; wdata = 32'h0;
    @(negedge clk);
    check32("abort_wait_dataOK", {31'b0, data_ok}, 32'h0);
    @(posedge clk);
    @(negedge clk);
    check32("abort_dataOK", {31'b0, data_ok}, 32'h0);
    check32("abort_din", din, 32'h0);
    check32("abort_err_cleared", {31'b0, err}, 32'h0);
    @(posedge clk);
    #1;
    rstn = 1'b1;
    repeat (4) @(posedge clk);
    issue("rd_after_reset", 1'b0, 2'd2, 4'h0, 32'h20,   32'h0,        32'h0);

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
